// File: rtl/vector_store_sequencer.sv
// Vector store sequencer: captures one multi-lane ALU result and writes its
// enabled lanes to byte-wide data memory in ascending lane order.
module vector_store_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  input  logic [LANES*LANE_W-1:0]   vec_data,
  input  logic [ADDR_W-1:0]         vec_base,
  input  logic [LANES-1:0]          lane_mask,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LANE_W-1:0]         mem_wdata,
  output logic                      busy,
  output logic                      done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [LANES*LANE_W-1:0]   r_data;
  logic [ADDR_W-1:0]         r_base;
  logic [LANES-1:0]          r_pending;

  logic [IDX_W-1:0]          w_cur;
  logic                      w_found;
  logic [LANE_W-1:0]         w_wdata;
  logic [LANES-1:0]          w_cur_onehot;
  logic [LANES-1:0]          w_remaining;
  logic                      w_accept;
  logic                      w_complete;

  // Lowest pending lane; all outputs derive from registers so they hold while stalled.
  always_comb begin
    w_cur   = '0;
    w_found = 1'b0;
    w_wdata = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_pending[i] && !w_found) begin
        w_cur   = IDX_W'(i);
        w_found = 1'b1;
        w_wdata = r_data[i*LANE_W +: LANE_W];
      end
    end
  end

  assign w_cur_onehot = {{(LANES-1){1'b0}}, 1'b1} << w_cur;
  assign w_remaining  = r_pending & ~w_cur_onehot;
  assign w_accept     = vec_valid && (r_state == S_IDLE);
  assign w_complete   = (r_state == S_WRITE) && mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (lane_mask != '0) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        if (w_complete && (w_remaining == '0)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_base    <= '0;
      r_pending <= '0;
    end else if (w_accept) begin
      r_data    <= vec_data;
      r_base    <= vec_base;
      r_pending <= lane_mask;
    end else if (w_complete) begin
      r_pending <= w_remaining;
    end
  end

  assign vec_ready = (r_state == S_IDLE);
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_base + ADDR_W'(w_cur);
  assign mem_wdata = w_wdata;
  assign busy      = (r_state == S_WRITE) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_vector_store_sequencer.sv
// Directed, table-driven bench for vector_store_sequencer with hand-written
// backpressure and mid-request reset sequences.
module tb_vector_store_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vec_valid;
  logic         vec_ready;
  logic [127:0] vec_data;
  logic [11:0]  vec_base;
  logic [15:0]  lane_mask;
  logic         mem_we;
  logic         mem_ready;
  logic [11:0]  mem_addr;
  logic [7:0]   mem_wdata;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  vector_store_sequencer #(.LANES(16), .LANE_W(8), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_base(vec_base), .lane_mask(lane_mask),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  // Independent count of completed memory writes seen on the bus.
  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ready) wr_count <= wr_count + 1;
  end

  typedef struct {
    string       name;
    logic [11:0] base;
    logic [15:0] mask;
    logic [7:0]  salt;
    int          stall_lane;
    int          stall_cycles;
    int          exp_writes;
    int          exp_done_cyc;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic do_req(input vec_t v);
    logic [15:0] rem;
    logic [11:0] first_a, last_a;
    logic [11:0] exp_a;
    int nwr, stalls, cyc, lane;
    bit  seen_done;
    rem = v.mask; nwr = 0; stalls = v.stall_cycles; seen_done = 0; cyc = 0;
    first_a = '0; last_a = '0;
    @(negedge clk);
    chk({v.name, "_ready_idle"}, {31'd0, vec_ready}, 32'd1);
    vec_valid = 1'b1;
    vec_base  = v.base;
    lane_mask = v.mask;
    for (int i = 0; i < 16; i++) vec_data[i*8 +: 8] = 8'(v.salt + 8'(i));
    @(negedge clk);
    vec_valid = 1'b0;
    vec_base  = 12'(  $urandom);
    lane_mask = 16'(  $urandom);
    vec_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 40; c++) begin
      cyc = c;
      if (done) begin
        seen_done = 1;
        break;
      end
      if (mem_we) begin
        lane = -1;
        for (int i = 15; i >= 0; i--) if (rem[i]) lane = i;
        exp_a = v.base + 12'(lane);
        chk({v.name, "_addr"}, {20'd0, mem_addr}, {20'd0, exp_a});
        chk({v.name, "_wdata"}, {24'd0, mem_wdata}, {24'd0, 8'(v.salt + 8'(lane))});
        chk({v.name, "_busy_wr"}, {30'd0, busy, vec_ready}, 32'd2);
        if (lane == v.stall_lane && stalls > 0) begin
          mem_ready = 1'b0;
          stalls--;
        end else begin
          mem_ready = 1'b1;
          if (nwr == 0) first_a = mem_addr;
          last_a = mem_addr;
          if (lane >= 0) rem[lane] = 1'b0;
          nwr++;
        end
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    chk({v.name, "_done_seen"}, {31'd0, seen_done}, 32'd1);
    chk({v.name, "_done_cyc"}, cyc, v.exp_done_cyc);
    chk({v.name, "_nwrites"}, nwr, v.exp_writes);
    chk({v.name, "_done_state"}, {29'd0, mem_we, busy, vec_ready}, 32'd2);
    if (v.exp_writes > 0) begin
      chk({v.name, "_first"}, {20'd0, first_a}, {20'd0, v.exp_first});
      chk({v.name, "_last"}, {20'd0, last_a}, {20'd0, v.exp_last});
    end
    @(negedge clk);
    chk({v.name, "_after"}, {30'd0, vec_ready, done}, 32'd2);
  endtask

  vec_t tbl[6];
  int   wc0;

  initial begin
    rst_n = 1'b0; vec_valid = 1'b0; vec_data = '0; vec_base = '0;
    lane_mask = '0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {mem_we, busy, done, vec_ready}, 32'h1);
    chk("reset_addr", {12'd0, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;

    tbl[0] = '{"T1_full",   12'h100, 16'hFFFF, 8'h10, -1, 0, 16, 17, 12'h100, 12'h10F};
    tbl[1] = '{"T2_sparse", 12'h020, 16'h8001, 8'h40, -1, 0,  2,  3, 12'h020, 12'h02F};
    tbl[2] = '{"T3_wrap",   12'hFFE, 16'h000F, 8'h80, -1, 0,  4,  5, 12'hFFE, 12'h001};
    tbl[3] = '{"T4_bp",     12'h200, 16'h0007, 8'h30,  1, 3,  3,  7, 12'h200, 12'h202};
    tbl[4] = '{"T5_empty",  12'h300, 16'h0000, 8'h00, -1, 0,  0,  1, 12'h000, 12'h000};
    tbl[5] = '{"T_high",    12'h0F0, 16'hA000, 8'hC0, -1, 0,  2,  3, 12'h0FD, 12'h0FF};

    for (int t = 0; t < 6; t++) begin
      wc0 = wr_count;
      do_req(tbl[t]);
      chk({tbl[t].name, "_buswrites"}, wr_count - wc0, tbl[t].exp_writes);
    end

    // Reset in the middle of a full-mask request.
    wc0 = wr_count;
    @(negedge clk);
    vec_valid = 1'b1; vec_base = 12'h100; lane_mask = 16'hFFFF;
    for (int i = 0; i < 16; i++) vec_data[i*8 +: 8] = 8'(8'h10 + 8'(i));
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (5) begin
      chk("T6_we_pre", {31'd0, mem_we}, 32'd1);
      @(negedge clk);
    end
    chk("T6_addr_6th", {20'd0, mem_addr}, 32'h105);
    rst_n = 1'b0;
    @(negedge clk);
    chk("T6_rst_outs", {mem_we, busy, done, vec_ready}, 32'h1);
    chk("T6_rst_addr", {12'd0, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("T6_no_we", {30'd0, mem_we, busy}, 32'd0);
    end
    chk("T6_writes", wr_count - wc0, 5);
    do_req(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
